// File: rtl/ph_scan_scheduler.sv
// ph_scan_scheduler: shares one combinational blood pH analyzer among NUM_CH
// sensor channels. A round-robin arbiter picks a requesting channel, its pH is
// held on the analyzer for SETTLE cycles, the abnormality flags are captured,
// and per-channel consecutive-abnormal counters drive sticky alarms.
module ph_scan_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int SETTLE  = 2,
    parameter int CONFIRM = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         chReq,
    input  logic [4*NUM_CH-1:0]       chPH,
    input  logic [NUM_CH-1:0]         alarmClr,
    input  logic                      abnP,
    input  logic                      abnQ,
    output logic [3:0]                phOut,
    output logic [NUM_CH-1:0]         chAck,
    output logic [$clog2(NUM_CH)-1:0] curCh,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH-1:0]         lastAbnP,
    output logic [NUM_CH-1:0]         lastAbnQ,
    output logic [NUM_CH-1:0]         alarm
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(CONFIRM + 1);
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] CONF_V      = CNT_W'(CONFIRM);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [CH_W-1:0]       curCh_q, curCh_d;
    logic [3:0]            phOut_q, phOut_d;
    logic [NUM_CH-1:0]     chAck_q, chAck_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic [NUM_CH-1:0]     lastP_q, lastP_d;
    logic [NUM_CH-1:0]     lastQ_q, lastQ_d;
    logic [NUM_CH-1:0]     alarm_q, alarm_d;
    logic [CNT_W-1:0]      cnt_q [NUM_CH];
    logic [CNT_W-1:0]      cnt_d [NUM_CH];

    logic [CH_W-1:0]       winHi, winAll, winner;
    logic                  foundHi, foundAll, grant;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall (wrap)
    always_comb begin
        winHi    = '0;
        winAll   = '0;
        foundHi  = 1'b0;
        foundAll = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chReq[i] && (CH_W'(i) >= ptr_q)) begin
                winHi   = CH_W'(i);
                foundHi = 1'b1;
            end
            if (chReq[i]) begin
                winAll   = CH_W'(i);
                foundAll = 1'b1;
            end
        end
        winner = foundHi ? winHi : winAll;
        grant  = (state_q == S_IDLE) && enable && foundAll;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            curCh_q  <= '0;
            phOut_q  <= '0;
            chAck_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            settle_q <= '0;
            lastP_q  <= '0;
            lastQ_q  <= '0;
            alarm_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            curCh_q  <= curCh_d;
            phOut_q  <= phOut_d;
            chAck_q  <= chAck_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            settle_q <= settle_d;
            lastP_q  <= lastP_d;
            lastQ_q  <= lastQ_d;
            alarm_q  <= alarm_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Next-state logic: grant -> load pH -> settle countdown -> back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant) state_d = S_LOAD;
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: if (settle_q == '0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic per state, with alarm clears overriding any capture
    always_comb begin
        ptr_d    = ptr_q;
        curCh_d  = curCh_q;
        phOut_d  = phOut_q;
        chAck_d  = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        settle_d = settle_q;
        lastP_d  = lastP_q;
        lastQ_d  = lastQ_q;
        alarm_d  = alarm_q;
        for (int i = 0; i < NUM_CH; i++) cnt_d[i] = cnt_q[i];

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    curCh_d = winner;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (curCh_q == CH_W'(i)) begin
                        phOut_d    = chPH[4*i +: 4];
                        chAck_d[i] = 1'b1;
                    end
                end
                ptr_d    = (curCh_q == LAST_CH) ? '0 : curCh_q + 1'b1;
                settle_d = SETTLE_INIT;
            end
            S_SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (curCh_q == CH_W'(i)) begin
                            lastP_d[i] = abnP;
                            lastQ_d[i] = abnQ;
                            if (abnP || abnQ)
                                cnt_d[i] = (cnt_q[i] == CONF_V) ? CONF_V : cnt_q[i] + 1'b1;
                            else
                                cnt_d[i] = '0;
                            if (cnt_d[i] == CONF_V) alarm_d[i] = 1'b1;
                        end
                    end
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            if (alarmClr[i]) begin
                alarm_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end
        end
    end

    assign phOut    = phOut_q;
    assign chAck    = chAck_q;
    assign curCh    = curCh_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign lastAbnP = lastP_q;
    assign lastAbnQ = lastQ_q;
    assign alarm    = alarm_q;

endmodule
